// File: rtl/imem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// imem_ctrl_pkg
// Shared types and default sizes for the instruction-memory load controller.
//   imem_state_t      : controller FSM encoding (IDLE, LOAD, DRAIN, RUN)
//   IMEM_ADDR_W       : default instruction RAM address width (64 words)
//   IMEM_DATA_W       : default instruction word width
//   IMEM_DRAIN_CYCLES : default idle gap between the last write and CPU release
// ---------------------------------------------------------------------------
package imem_ctrl_pkg;

  localparam int IMEM_ADDR_W       = 6;
  localparam int IMEM_DATA_W       = 32;
  localparam int IMEM_DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    RUN   = 2'd3
  } imem_state_t;

endpackage

// File: rtl/imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl
// Owns the single instruction-RAM port. While a program streams in from the
// loader, the CPU is held and loader words are written (one registered write
// per word). Once the loader signals done, the block waits DRAIN_CYCLES idle
// cycles so the last write settles, then releases the CPU and passes the port
// straight through to instruction fetch. A reload request in RUN restarts
// the loader and goes back to loading.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   ld_valid/ld_data/ld_addr : loader word stream (ld_addr is a word index)
//   ld_done              : loader finished (level)
//   ld_restart           : one-cycle pulse asking the loader to start over
//   reload               : reprogram request, honoured only in RUN
//   cpu_fetch_req/addr   : CPU fetch request and address
//   cpu_fetch_gnt        : fetch granted this cycle (RUN only)
//   cpu_run              : CPU released from hold
//   mem_en/we/addr/wdata : instruction RAM port
//   words_loaded         : in-range words written in the current load
//   err_oob              : sticky, a word addressed beyond the RAM was dropped
//   err_late             : sticky, a loader word arrived in DRAIN or RUN
//   state                : FSM state for debug
// Parameters
//   ADDR_W, DATA_W, DRAIN_CYCLES (DRAIN_CYCLES must be at least 1)
// ---------------------------------------------------------------------------
module imem_load_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_W       = IMEM_ADDR_W,
  parameter int DATA_W       = IMEM_DATA_W,
  parameter int DRAIN_CYCLES = IMEM_DRAIN_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [31:0]       ld_addr,
  input  logic              ld_done,
  output logic              ld_restart,
  input  logic              reload,
  input  logic              cpu_fetch_req,
  input  logic [ADDR_W-1:0] cpu_fetch_addr,
  output logic              cpu_fetch_gnt,
  output logic              cpu_run,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   words_loaded,
  output logic              err_oob,
  output logic              err_late,
  output logic [1:0]        state
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

  imem_state_t       state_q;
  logic              ld_done_q;
  logic [CNT_W-1:0]  drain_cnt;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic done_edge;
  logic addr_ok;
  logic in_run;

  // Decode helpers: the loader's done is a level, so only its rising edge
  // ends a load; an address is usable only if no bits above the RAM
  // index are set.
  always_comb begin
    done_edge = ld_done & ~ld_done_q;
    addr_ok   = (ld_addr[31:ADDR_W] == '0);
    in_run    = (state_q == RUN);
  end

  // Main controller. Loader writes are captured into a one-deep write
  // register so the RAM sees them one cycle later. ld_done_q follows
  // ld_done even across a reload, so a done level still high from the
  // previous program is not mistaken for a new completion: the loader
  // has to drop and re-raise it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ld_done_q    <= 1'b0;
      drain_cnt    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      words_loaded <= '0;
      err_oob      <= 1'b0;
      err_late     <= 1'b0;
      ld_restart   <= 1'b0;
      cpu_run      <= 1'b0;
    end else begin
      ld_done_q  <= ld_done;
      ld_restart <= 1'b0;
      wr_en_q    <= 1'b0;
      case (state_q)
        IDLE, LOAD: begin
          if (ld_valid) begin
            if (addr_ok) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= ld_addr[ADDR_W-1:0];
              wr_data_q <= ld_data;
              if (words_loaded != WORDS_MAX) begin
                words_loaded <= words_loaded + 1'b1;
              end
            end else begin
              err_oob <= 1'b1;
            end
          end
          // A word arriving with the done edge is still written above;
          // the write lands in the first DRAIN cycle.
          if (done_edge) begin
            state_q   <= DRAIN;
            drain_cnt <= '0;
          end else if (ld_valid) begin
            state_q <= LOAD;
          end
        end
        DRAIN: begin
          if (ld_valid) begin
            err_late <= 1'b1;
          end
          if (drain_cnt == CNT_LAST) begin
            state_q <= RUN;
            cpu_run <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        RUN: begin
          if (reload) begin
            state_q      <= LOAD;
            cpu_run      <= 1'b0;
            ld_restart   <= 1'b1;
            words_loaded <= '0;
            err_oob      <= 1'b0;
            err_late     <= 1'b0;
          end else if (ld_valid) begin
            err_late <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM port steering: in RUN the fetch unit drives the port directly so a
  // fetch costs no extra cycle; otherwise the registered loader write owns it.
  always_comb begin
    cpu_fetch_gnt = in_run & cpu_fetch_req;
    mem_en        = in_run ? cpu_fetch_req : wr_en_q;
    mem_we        = ~in_run & wr_en_q;
    mem_addr      = in_run ? cpu_fetch_addr : wr_addr_q;
    mem_wdata     = wr_data_q;
    state         = state_q;
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_load_ctrl
// Directed bench for imem_load_ctrl: a normal 28-word load, a table of
// vectors covering RUN fetch, late/out-of-range words, reload and a word
// coincident with done, then an asynchronous reset mid-load followed by a
// full reload that also drives words_loaded into saturation.
// ---------------------------------------------------------------------------
module tb_imem_load_ctrl;
  import imem_ctrl_pkg::*;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic [31:0]   ld_addr;
  logic          ld_done;
  logic          ld_restart;
  logic          reload;
  logic          cpu_fetch_req;
  logic [AW-1:0] cpu_fetch_addr;
  logic          cpu_fetch_gnt;
  logic          cpu_run;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [AW:0]   words_loaded;
  logic          err_oob;
  logic          err_late;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic        done;
    logic        rl;
    logic        rq;
    logic [5:0]  fa;
    logic [1:0]  e_state;
    logic        e_en;
    logic        e_we;
    logic [5:0]  e_addr;
    logic [31:0] e_wdata;
    logic [6:0]  e_words;
    logic        e_run;
    logic        e_gnt;
    logic        e_restart;
    logic        e_oob;
    logic        e_late;
  } vec_t;

  imem_load_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DRAIN_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .ld_addr        (ld_addr),
    .ld_done        (ld_done),
    .ld_restart     (ld_restart),
    .reload         (reload),
    .cpu_fetch_req  (cpu_fetch_req),
    .cpu_fetch_addr (cpu_fetch_addr),
    .cpu_fetch_gnt  (cpu_fetch_gnt),
    .cpu_run        (cpu_run),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .words_loaded   (words_loaded),
    .err_oob        (err_oob),
    .err_late       (err_late),
    .state          (state)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input string n, input logic v, input logic [31:0] a,
                              input logic [31:0] d, input logic done, input logic rl,
                              input logic rq, input logic [5:0] fa, input logic [1:0] st,
                              input logic en, input logic we, input logic [5:0] ma,
                              input logic [31:0] wd, input logic [6:0] wl, input logic run,
                              input logic gnt, input logic rs, input logic oob,
                              input logic late);
    vec_t r;
    r.name = n; r.v = v; r.a = a; r.d = d; r.done = done; r.rl = rl; r.rq = rq; r.fa = fa;
    r.e_state = st; r.e_en = en; r.e_we = we; r.e_addr = ma; r.e_wdata = wd;
    r.e_words = wl; r.e_run = run; r.e_gnt = gnt; r.e_restart = rs;
    r.e_oob = oob; r.e_late = late;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one vector's inputs, clock it in, and settle just after the edge.
  task automatic applyStimulus(input vec_t t);
    ld_valid       = t.v;
    ld_addr        = t.a;
    ld_data        = t.d;
    ld_done        = t.done;
    reload         = t.rl;
    cpu_fetch_req  = t.rq;
    cpu_fetch_addr = t.fa;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t t);
    chk({t.name, ".state"},    32'(state),         32'(t.e_state));
    chk({t.name, ".mem_en"},   32'(mem_en),        32'(t.e_en));
    chk({t.name, ".mem_we"},   32'(mem_we),        32'(t.e_we));
    if (t.e_en)
      chk({t.name, ".mem_addr"}, 32'(mem_addr),    32'(t.e_addr));
    if (t.e_we)
      chk({t.name, ".mem_wdata"}, mem_wdata,       t.e_wdata);
    chk({t.name, ".words"},    32'(words_loaded),  32'(t.e_words));
    chk({t.name, ".cpu_run"},  32'(cpu_run),       32'(t.e_run));
    chk({t.name, ".gnt"},      32'(cpu_fetch_gnt), 32'(t.e_gnt));
    chk({t.name, ".restart"},  32'(ld_restart),    32'(t.e_restart));
    chk({t.name, ".err_oob"},  32'(err_oob),       32'(t.e_oob));
    chk({t.name, ".err_late"}, 32'(err_late),      32'(t.e_late));
  endtask

  task automatic checkReset(input string name);
    chk({name, ".state"},     32'(state),         32'(IDLE));
    chk({name, ".mem_en"},    32'(mem_en),        0);
    chk({name, ".mem_we"},    32'(mem_we),        0);
    chk({name, ".mem_addr"},  32'(mem_addr),      0);
    chk({name, ".mem_wdata"}, mem_wdata,          0);
    chk({name, ".words"},     32'(words_loaded),  0);
    chk({name, ".cpu_run"},   32'(cpu_run),       0);
    chk({name, ".gnt"},       32'(cpu_fetch_gnt), 0);
    chk({name, ".restart"},   32'(ld_restart),    0);
    chk({name, ".err_oob"},   32'(err_oob),       0);
    chk({name, ".err_late"},  32'(err_late),      0);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t t;
    int   wl;

    // Vectors applied from RUN after the first load (28 words, ld_done high).
    tbl.push_back(mk("run_fetch",     0, 0, 0, 1, 0, 1, 6'h1F, 3, 1, 0, 6'h1F, 0, 28, 1, 1, 0, 0, 0));
    tbl.push_back(mk("run_no_req",    0, 0, 0, 1, 0, 0, 6'h1F, 3, 0, 0, 0, 0, 28, 1, 0, 0, 0, 0));
    tbl.push_back(mk("run_late",      1, 3, 32'h1234_5678, 1, 0, 0, 0, 3, 0, 0, 0, 0, 28, 1, 0, 0, 0, 1));
    tbl.push_back(mk("late_sticky",   0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 28, 1, 0, 0, 0, 1));
    tbl.push_back(mk("reload",        0, 0, 0, 1, 1, 1, 6'h02, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("restart_pulse", 0, 0, 0, 1, 0, 1, 6'h02, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("done_held",     0, 0, 0, 1, 0, 1, 6'h02, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("reload_in_load",0, 0, 0, 1, 1, 1, 6'h02, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("done_low",      0, 0, 0, 0, 0, 1, 6'h02, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("w0",            1, 0, 32'hBEEF_0000, 0, 0, 1, 6'h02, 1, 1, 1, 0, 32'hBEEF_0000, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("oob",           1, 64, 32'hBEEF_00FF, 0, 0, 1, 6'h02, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("w1",            1, 1, 32'hBEEF_0001, 0, 0, 1, 6'h02, 1, 1, 1, 1, 32'hBEEF_0001, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk("w2",            1, 2, 32'hBEEF_0002, 0, 0, 1, 6'h02, 1, 1, 1, 2, 32'hBEEF_0002, 3, 0, 0, 0, 1, 0));
    tbl.push_back(mk("w3",            1, 3, 32'hBEEF_0003, 0, 0, 1, 6'h02, 1, 1, 1, 3, 32'hBEEF_0003, 4, 0, 0, 0, 1, 0));
    tbl.push_back(mk("w4",            1, 4, 32'hBEEF_0004, 0, 0, 1, 6'h02, 1, 1, 1, 4, 32'hBEEF_0004, 5, 0, 0, 0, 1, 0));
    tbl.push_back(mk("w5_done",       1, 5, 32'hBEEF_0005, 1, 0, 1, 6'h02, 2, 1, 1, 5, 32'hBEEF_0005, 6, 0, 0, 0, 1, 0));
    tbl.push_back(mk("drain_late",    1, 7, 32'hBEEF_0007, 1, 0, 1, 6'h02, 2, 0, 0, 0, 0, 6, 0, 0, 0, 1, 1));
    tbl.push_back(mk("drain_to_run",  0, 0, 0, 1, 0, 1, 6'h1F, 3, 1, 0, 6'h1F, 0, 6, 1, 1, 0, 1, 1));

    // Reset state.
    rst_n = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    reload = 1'b0; cpu_fetch_req = 1'b0; cpu_fetch_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Normal load: 28 words, fetch request held high to prove no grant.
    for (int i = 0; i < 28; i++) begin
      t = mk($sformatf("load%0d", i), 1, 32'(i), 32'hC0DE_0000 | 32'(i), 0, 0, 1, 6'(i),
             1, 1, 1, 6'(i), 32'hC0DE_0000 | 32'(i), 7'(i + 1), 0, 0, 0, 0, 0);
      applyStimulus(t);
      checkOutput(t);
    end
    t = mk("done_edge", 0, 0, 0, 1, 0, 1, 0, 2, 0, 0, 0, 0, 28, 0, 0, 0, 0, 0);
    applyStimulus(t); checkOutput(t);
    t = mk("drain2",    0, 0, 0, 1, 0, 1, 0, 2, 0, 0, 0, 0, 28, 0, 0, 0, 0, 0);
    applyStimulus(t); checkOutput(t);
    t = mk("run_rise",  0, 0, 0, 1, 0, 1, 0, 3, 1, 0, 0, 0, 28, 1, 1, 0, 0, 0);
    applyStimulus(t); checkOutput(t);

    // Table: fetch, late word, reload, out-of-range, word with done edge.
    foreach (tbl[k]) begin
      applyStimulus(tbl[k]);
      checkOutput(tbl[k]);
    end

    // Reload, then reset asynchronously after 10 words.
    t = mk("reload2",  0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(t); checkOutput(t);
    t = mk("done_low2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(t); checkOutput(t);
    for (int i = 0; i < 10; i++) begin
      t = mk($sformatf("pre_rst%0d", i), 1, 32'(i + 10), 32'hCAFE_0000 | 32'(i), 0, 0, 0, 0,
             1, 1, 1, 6'(i + 10), 32'hCAFE_0000 | 32'(i), 7'(i + 1), 0, 0, 0, 0, 0);
      applyStimulus(t);
      checkOutput(t);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("async_reset");
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Full reload after reset: 66 words (addresses wrap) saturate the counter.
    for (int i = 0; i < 66; i++) begin
      wl = (i + 1 > 64) ? 64 : i + 1;
      t = mk($sformatf("reload_w%0d", i), 1, 32'(i % 64), 32'h5A5A_0000 | 32'(i), 0, 0, 1, 0,
             1, 1, 1, 6'(i % 64), 32'h5A5A_0000 | 32'(i), 7'(wl), 0, 0, 0, 0, 0);
      applyStimulus(t);
      checkOutput(t);
    end
    t = mk("final_done",  0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 64, 0, 0, 0, 0, 0);
    applyStimulus(t); checkOutput(t);
    t = mk("final_drain", 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 64, 0, 0, 0, 0, 0);
    applyStimulus(t); checkOutput(t);
    t = mk("final_run",   0, 0, 0, 1, 0, 1, 6'h2A, 3, 1, 0, 6'h2A, 0, 64, 1, 1, 0, 0, 0);
    applyStimulus(t); checkOutput(t);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
